// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: FSM/direction types and level helper for counter_step_arbiter
package counter_arb_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, DONE} state_e;
  typedef enum logic [1:0] {DIR_UP, DIR_DN, DIR_BAD} dir_e;
  function automatic int level_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/counter_step_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner select (fixed priority under CNT_ARB_FIXED_PRIO_EN)
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] active_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o
);
  int j;
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    j = 0;
    // Scan from lowest priority upward so the highest-priority hit is written last
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr_i) + k) % NREQ;
`endif
      if (active_i[j]) begin
        onehot_o = '0;
        onehot_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/counter_step_arbiter.sv
// counter_step_arbiter: round-robin shared 3-bit saturating counter stepper with shadow level.
// CNT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and removes the pointer.
module counter_step_arbiter #(
  parameter int NREQ = 4,
  parameter int LEVEL_W = 3,
  parameter int SETTLE = 2
) (
  input  logic               CLK,
  input  logic               MR,
  input  logic [NREQ-1:0]    req_up,
  input  logic [NREQ-1:0]    req_dn,
  output logic [NREQ-1:0]    grant,
  output logic               done,
  output logic               reject,
  output logic               UP,
  output logic               DOWN,
  output logic [LEVEL_W-1:0] level,
  output logic               at_max,
  output logic               at_min
);
  import counter_arb_pkg::*;
  localparam int IW = $clog2(NREQ);
  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(level_max(LEVEL_W));
  state_e state_q, state_d;
  dir_e dir_q, dir_d;
  logic [NREQ-1:0] win_q, win_d, pick_oh, active;
  logic [IW-1:0] widx_q, widx_d, pick_idx, ptr;
  logic [3:0] cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic refuse_q, refuse_d, refuse;
  assign active = req_up | req_dn;
`ifdef CNT_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] ptr_q;
  assign ptr = ptr_q;
  always_ff @(posedge CLK or posedge MR)
    if (MR) ptr_q <= '0;
    else if (state_q == DONE) ptr_q <= widx_q == IW'(NREQ - 1) ? '0 : widx_q + 1'b1;
`endif
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .active_i(active),
    .ptr_i(ptr),
    .onehot_o(pick_oh),
    .idx_o(pick_idx)
  );
  // Outputs decode straight from state so MR drops them without waiting for a clock
  assign grant = state_q == IDLE ? '0 : win_q;
  assign UP = state_q == PULSE && dir_q == DIR_UP && level_q != LMAX;
  assign DOWN = state_q == PULSE && dir_q == DIR_DN && level_q != '0;
  assign refuse = !(UP || DOWN);
  assign done = state_q == DONE;
  assign reject = done && refuse_q;
  assign level = level_q;
  assign at_max = level_q == LMAX;
  assign at_min = level_q == '0;
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    win_d = win_q;
    widx_d = widx_q;
    cnt_d = cnt_q;
    level_d = level_q;
    refuse_d = refuse_q;
    case (state_q)
      IDLE: if (|active) begin
        state_d = PULSE;
        win_d = pick_oh;
        widx_d = pick_idx;
        dir_d = |(req_up & req_dn & pick_oh) ? DIR_BAD : |(req_up & pick_oh) ? DIR_UP : DIR_DN;
      end
      PULSE: begin
        refuse_d = refuse;
        cnt_d = '0;
        state_d = refuse ? DONE : counter_arb_pkg::SETTLE;
        level_d = UP ? level_q + 1'b1 : DOWN ? level_q - 1'b1 : level_q;
      end
      counter_arb_pkg::SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == 4'(SETTLE - 1) ? DONE : counter_arb_pkg::SETTLE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge MR)
    if (MR) begin
      state_q <= IDLE;
      dir_q <= DIR_UP;
      win_q <= '0;
      widx_q <= '0;
      cnt_q <= '0;
      level_q <= '0;
      refuse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      win_q <= win_d;
      widx_q <= widx_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      refuse_q <= refuse_d;
    end
endmodule

// File: tb/tb_counter_step_arbiter.sv
// tb_counter_step_arbiter: scoreboard bench with a queue-based reference model
module tb_counter_step_arbiter;
  localparam int NREQ = 4;
  localparam int LEVEL_W = 3;
  localparam int SETTLE = 2;
  localparam int LMAX = 7;
  logic CLK = 0;
  logic MR = 0;
  logic [NREQ-1:0] req_up = '0, req_dn = '0, grant;
  logic done, reject, UP, DOWN, at_max, at_min;
  logic [LEVEL_W-1:0] level;
  typedef struct { int g; int rej; int lvl; int up; int dn; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, lvl_m = 0, ptr_m = 0;

  counter_step_arbiter #(.NREQ(NREQ), .LEVEL_W(LEVEL_W), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .MR(MR), .req_up(req_up), .req_dn(req_dn), .grant(grant),
    .done(done), .reject(reject), .UP(UP), .DOWN(DOWN), .level(level),
    .at_max(at_max), .at_min(at_min)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  // Reference: walk from the pointer to the first active requester, apply saturating step
  function automatic exp_t model(input logic [NREQ-1:0] u, input logic [NREQ-1:0] d);
    exp_t e;
    int w;
    w = ptr_m;
    while (!(u[w] | d[w])) w = (w + 1) % NREQ;
    e.g = 1 << w;
    e.rej = int'((u[w] && d[w]) || (u[w] && lvl_m == LMAX) || (!u[w] && lvl_m == 0));
    e.up = int'(e.rej == 0 && u[w]);
    e.dn = int'(e.rej == 0 && !u[w]);
    lvl_m = lvl_m + e.up - e.dn;
    e.lvl = lvl_m;
`ifndef CNT_ARB_FIXED_PRIO_EN
    ptr_m = (w + 1) % NREQ;
`endif
    return e;
  endfunction

  task automatic run_txn(input logic [NREQ-1:0] u, input logic [NREQ-1:0] d);
    exp_t e;
    int n;
    e = model(u, d);
    q.push_back(e);
    req_up = u;
    req_dn = d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done && n < 50);
    chk("latency", n, e.rej != 0 ? 3 : 3 + SETTLE);
    @(posedge CLK);
    #1;
    req_up = '0;
    req_dn = '0;
  endtask

  initial begin
    int len, su, sd, both;
    exp_t e;
    len = 0; su = 0; sd = 0; both = 0;
    forever begin
      @(negedge CLK);
      if (MR) begin
        len = 0; su = 0; sd = 0; both = 0;
      end else begin
        if (grant != '0) begin
          len++;
          su += int'(UP);
          sd += int'(DOWN);
          both += int'(UP && DOWN);
        end
        if (done) begin
          chk("sb_nonempty", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", int'(grant), e.g);
            chk("reject", int'(reject), e.rej);
            chk("level", int'(level), e.lvl);
            chk("at_max", int'(at_max), int'(e.lvl == LMAX));
            chk("at_min", int'(at_min), int'(e.lvl == 0));
            chk("up_pulses", su, e.up);
            chk("dn_pulses", sd, e.dn);
            chk("grant_len", len, e.rej != 0 ? 2 : SETTLE + 2);
            chk("strobe_excl", both, 0);
          end
          len = 0; su = 0; sd = 0; both = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int guard;
    logic [NREQ-1:0] u, d;
    #1 MR = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_up", int'(UP), 0);
    chk("rst_down", int'(DOWN), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_at_min", int'(at_min), 1);
    chk("rst_at_max", int'(at_max), 0);
    MR = 0;
    @(posedge CLK);
    #1;
    run_txn(4'b0000, 4'b0100);
    run_txn(4'b0001, 4'b0000);
    repeat (10) run_txn(4'b1111, 4'b0000);
    run_txn(4'b0010, 4'b1010);
    run_txn(4'b0010, 4'b1010);
    guard = 0;
    while (lvl_m != 5 && guard < 20) begin
      if (lvl_m > 5) run_txn(4'b0000, 4'b0001);
      else run_txn(4'b0001, 4'b0000);
      guard++;
    end
    chk("pre_abort_level", int'(level), 5);
    e = model(4'b0001, 4'b0000);
    req_up = 4'b0001;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_grant_held", int'(grant), e.g);
    #1 MR = 1;
    #1;
    chk("abort_grant", int'(grant), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_up", int'(UP), 0);
    chk("abort_down", int'(DOWN), 0);
    chk("abort_level", int'(level), 0);
    q.delete();
    lvl_m = 0;
    ptr_m = 0;
    req_up = '0;
    @(posedge CLK);
    #2 MR = 0;
    @(posedge CLK);
    #1;
    run_txn(4'b0101, 4'b0000);
`ifdef CNT_ARB_FIXED_PRIO_EN
    repeat (5) run_txn(4'b1001, 4'b0000);
`endif
    repeat (40) begin
      u = NREQ'($urandom_range(0, 15));
      d = NREQ'($urandom & $urandom);
      if ((u | d) == '0) u = NREQ'(1 << $urandom_range(0, NREQ - 1));
      run_txn(u, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
    repeat (3) @(posedge CLK);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
